// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, presents it to a
// zero-latency instruction memory and registers the returned word into the
// IF/ID pipeline register. Handles decode stalls, redirects and fetch faults.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 4096,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_inst,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  // Highest word-aligned address whose full 32-bit word lies inside memory.
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  // A PC is unusable if it is not word aligned or its word runs past memory.
  function automatic logic is_bad_pc(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr > LAST_PC);
  endfunction

  state_t      state_p0;
  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;
  logic        bad_pc_p0;

  logic        vld_p1;
  logic [31:0] pc_p1;
  logic [31:0] pc_plus4_p1;
  logic [31:0] inst_p1;
  logic        fault_p1;
  logic [31:0] count_p1;

  // Stage p0: fetch address, memory is read combinationally at the current PC.
  assign imem_addr   = pc_p0;
  assign pc_plus4_p0 = pc_p0 + 32'd4;
  assign bad_pc_p0   = is_bad_pc(pc_p0);

  // PC / FSM / IF-ID register update, priority rst > redirect > fault > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= ST_RUN;
      pc_p0       <= RESET_PC;
      vld_p1      <= 1'b0;
      pc_p1       <= 32'd0;
      pc_plus4_p1 <= 32'd0;
      inst_p1     <= NOP_INST;
      fault_p1    <= 1'b0;
      count_p1    <= 32'd0;
    end else if (redirect_valid) begin
      // The word fetched at the old PC is wrong-path and is dropped here.
      state_p0 <= ST_RUN;
      pc_p0    <= redirect_target;
      vld_p1   <= 1'b0;
      inst_p1  <= NOP_INST;
      fault_p1 <= 1'b0;
    end else if (state_p0 == ST_FAULT) begin
      // Parked until a redirect or reset; IF/ID already holds a bubble.
      vld_p1 <= 1'b0;
    end else if (stall) begin
      // Decode is not ready: everything holds.
      state_p0 <= ST_RUN;
    end else if (bad_pc_p0) begin
      state_p0 <= ST_FAULT;
      vld_p1   <= 1'b0;
      inst_p1  <= NOP_INST;
      fault_p1 <= 1'b1;
    end else begin
      // Stage p1: IF/ID capture of the word returned for the current PC.
      pc_p0       <= pc_plus4_p0;
      vld_p1      <= 1'b1;
      pc_p1       <= pc_p0;
      pc_plus4_p1 <= pc_plus4_p0;
      inst_p1     <= imem_data;
      count_p1    <= count_p1 + 32'd1;
    end
  end

  assign id_valid    = vld_p1;
  assign id_pc       = pc_p1;
  assign id_pc_plus4 = pc_plus4_p1;
  assign id_inst     = inst_p1;
  assign fetch_fault = fault_p1;
  assign fetch_count = count_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a behavioural memory,
// a reference model feeding a scoreboard queue, and fixed-value spot checks.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_inst;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] inst;
    logic        fault;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic        m_valid;
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_inst, m_count;
  logic        m_fault;

  // Memory contents: each word encodes its own word index.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd4096) return {16'hC0DE, 4'hA, a[11:2], 2'b11};
    return 32'hFFFF_FFFF;
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .IMEM_BYTES(4096),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .id_valid(id_valid),
    .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_inst(id_inst),
    .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Drive one cycle of inputs, predict, clock, then compare against the popped prediction.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rt);
    exp_t e;
    exp_t g;
    rst = r; stall = s; redirect_valid = rv; redirect_target = rt;
    if (r) begin
      m_pc = 32'd0; m_valid = 1'b0; m_id_pc = 32'd0; m_id_pc4 = 32'd0;
      m_inst = NOP; m_fault = 1'b0; m_count = 32'd0;
    end else if (rv) begin
      m_pc = rt; m_valid = 1'b0; m_inst = NOP; m_fault = 1'b0;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (s) begin
      m_valid = m_valid;
    end else if ((m_pc[1:0] != 2'b00) || (m_pc > 32'd4092)) begin
      m_fault = 1'b1; m_valid = 1'b0; m_inst = NOP;
    end else begin
      m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_inst = mem_word(m_pc);
      m_valid = 1'b1; m_count = m_count + 32'd1; m_pc = m_pc + 32'd4;
    end
    e = '{valid: m_valid, pc: m_pc, id_pc: m_id_pc, id_pc4: m_id_pc4,
          inst: m_inst, fault: m_fault, count: m_count};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      g = sb.pop_front();
      check("imem_addr",   imem_addr,             g.pc);
      check("id_valid",    {31'd0, id_valid},     {31'd0, g.valid});
      check("id_pc",       id_pc,                 g.id_pc);
      check("id_pc_plus4", id_pc_plus4,           g.id_pc4);
      check("id_inst",     id_inst,               g.inst);
      check("fetch_fault", {31'd0, fetch_fault},  {31'd0, g.fault});
      check("fetch_count", fetch_count,           g.count);
    end
  endtask

  initial begin
    m_pc = 0; m_valid = 0; m_id_pc = 0; m_id_pc4 = 0; m_inst = NOP; m_fault = 0; m_count = 0;

    // Reset then three straight fetches
    step(1, 0, 0, 0);
    check("rst_inst", id_inst, 32'h0000_0013);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t1_inst_c",  id_inst, 32'hC0DE_A00B);
    check("t1_pc",      id_pc, 32'h8);
    check("t1_count",   fetch_count, 32'd3);
    check("t1_addr",    imem_addr, 32'd12);

    // Stall two cycles while B sits in IF/ID
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t2_inst_b", id_inst, 32'hC0DE_A007);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("t2_hold_inst", id_inst, 32'hC0DE_A007);
    check("t2_hold_pc",   id_pc, 32'h4);
    check("t2_hold_addr", imem_addr, 32'h8);
    step(0, 0, 0, 0);
    check("t2_inst_c", id_inst, 32'hC0DE_A00B);
    check("t2_count",  fetch_count, 32'd3);

    // Redirect wins over stall
    step(0, 1, 1, 32'h40);
    check("t3_addr",  imem_addr, 32'h40);
    check("t3_valid", {31'd0, id_valid}, 32'd0);
    check("t3_inst",  id_inst, 32'h0000_0013);
    step(0, 0, 0, 0);
    check("t3_id_pc", id_pc, 32'h40);
    check("t3_inst2", id_inst, 32'hC0DE_A043);

    // Misaligned redirect faults; a good redirect recovers
    step(0, 0, 1, 32'h42);
    step(0, 0, 0, 0);
    check("t4_fault", {31'd0, fetch_fault}, 32'd1);
    check("t4_addr",  imem_addr, 32'h42);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'h10);
    check("t4_clear", {31'd0, fetch_fault}, 32'd0);
    step(0, 0, 0, 0);
    check("t4_id_pc", id_pc, 32'h10);

    // Run off the end of memory
    step(0, 0, 1, 32'hFF4);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t5_last_pc", id_pc, 32'hFFC);
    check("t5_addr",    imem_addr, 32'h1000);
    step(0, 0, 0, 0);
    check("t5_fault", {31'd0, fetch_fault}, 32'd1);
    check("t5_count", fetch_count, 32'd8);
    step(0, 0, 0, 0);

    // Reset from FAULT
    step(1, 0, 0, 0);
    check("t6_addr_a", imem_addr, 32'h0);
    check("t6_cnt_a",  fetch_count, 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    // Reset during stall
    step(1, 1, 0, 0);
    check("t6_addr_b", imem_addr, 32'h0);
    check("t6_pc_b",   id_pc, 32'h0);
    step(0, 0, 0, 0);

    // Redirect to a wrapping, out-of-range address
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("t7_fault", {31'd0, fetch_fault}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
